uart_rx_deframer: RTL and testbench

- Asynchronous serial receiver that turns the board UART RX pin into the byte stream `rx_data`/`new_rx_data` consumed directly by `cmd_parser`.
- Frame format: 8N1, LSB first, with an optional even-parity bit.
- Placement: between the FPGA RX pad and the command parser, in the 50 MHz board clock domain.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_deframer_sync2.sv | 28 ++
 rtl/uart_rx_deframer.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART receiver and the
// future transmitter.
//   CLK_FREQ_HZ          board clock frequency (50 MHz)
//   DEFAULT_BAUD         nominal line rate
//   DEFAULT_CLKS_PER_BIT board clocks per bit at DEFAULT_BAUD (434)
//   uart_state_e         3-bit frame-walker state encoding
package uart_pkg;

  localparam int unsigned CLK_FREQ_HZ          = 50000000;
  localparam int unsigned DEFAULT_BAUD         = 115200;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_FREQ_HZ / DEFAULT_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_deframer_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit.
//   RST_VAL  value both flops take during reset
//   clk, rst asynchronous active-high reset
//   d        asynchronous input
//   q        synchronized output (second flop)
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver (LSB first) feeding cmd_parser.
// Optional even parity bit when UART_RX_PARITY_EN is defined (11-bit frames).
//   CLKS_PER_BIT  clk cycles per bit, minimum 4
//   clk, rst      board clock, asynchronous active-high reset
//   rx            raw serial line from pad (idles high)
//   rx_data       last good byte, held until the next good frame
//   new_rx_data   one-cycle pulse when rx_data updates
//   frame_err     one-cycle pulse when the stop bit samples 0
//   parity_err    one-cycle pulse on parity mismatch (0 without parity)
//   busy          high whenever the receiver is not idle
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic rx_s;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_d;
  logic             new_d, ferr_d, perr_d, busy_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
`endif

  sync2 #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data;
    new_d     = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Re-check the start bit at its centre to reject glitches
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // bit_idx stops at 7 rather than wrapping into a ninth data bit
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: XOR of data and parity bit must be 0
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s};
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // Frame error wins over parity error; only a clean frame updates rx_data
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else
`endif
            begin
              rx_data_d = shift_q;
              new_d     = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Held-low line: wait for release so it cannot look like a new start
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data     <= 8'h00;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data     <= rx_data_d;
      new_rx_data <= new_d;
      frame_err   <= ferr_d;
      parity_err  <= perr_d;
      busy        <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict carried from the parity sample to the stop sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: self-checking bench for uart_rx_deframer at CLKS_PER_BIT=16.
// Table of frames with expected outputs, hand-written corner sequences, and a
// randomized run checked against a queue-based model of received bytes.
module tb_uart_rx_deframer;

  localparam int unsigned C  = 16;
  localparam int unsigned HB = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
  localparam bit          PAR   = 1'b1;
`else
  localparam int unsigned NBITS = 10;
  localparam bit          PAR   = 1'b0;
`endif
  // rx falling edge to new_rx_data, nominal
  localparam int unsigned LAT = 2 + HB + (NBITS - 1) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       new_rx_data, frame_err, parity_err, busy;

  uart_rx_deframer #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  byte unsigned got_data[$];
  int unsigned  got_cyc[$];
  int           new_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  bit           excl_bad = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (new_rx_data) begin
        got_data.push_back(rx_data);
        got_cyc.push_back(cyc);
        new_cnt++;
      end
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (int'(new_rx_data) + int'(frame_err) + int'(parity_err) > 1) excl_bad = 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Advance n rising edges, then step just past the edge before driving
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit bad_par);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(C);
    end
    if (PAR) begin
      rx = (^d) ^ bad_par;
      tick(C);
    end
    rx = stop_ok;
    tick(C);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    chk({nm, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         bad_par;
    int         exp_new;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] d, input bit so, input bit bp,
                              input int en, input int ef, input int ep,
                              input logic [7:0] ed);
    vec_t v;
    v.data = d; v.stop_ok = so; v.bad_par = bp;
    v.exp_new = en; v.exp_ferr = ef; v.exp_perr = ep; v.exp_data = ed;
    return v;
  endfunction

  vec_t         vecs[$];
  int           n0, f0, p0;
  int unsigned  t0;
  int           base_idx;
  byte unsigned exp_q[$];
  int           exp_ferr_r, exp_perr_r;
  logic [7:0]   rd;
  bit           rso, rbp;

  initial begin
    vecs.push_back(mk(8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5));
    vecs.push_back(mk(8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'hA5));
    vecs.push_back(mk(8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF));
    vecs.push_back(mk(8'h81, 1'b0, 1'b0, 0, 1, 0, 8'hFF));
`ifdef UART_RX_PARITY_EN
    vecs.push_back(mk(8'h03, 1'b1, 1'b0, 1, 0, 0, 8'h03));
    vecs.push_back(mk(8'h03, 1'b1, 1'b1, 0, 0, 1, 8'h03));
`endif
    vecs.push_back(mk(8'h5A, 1'b1, 1'b0, 1, 0, 0, 8'h5A));

    // Reset state
    tick(2);
    @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_new", 32'(new_rx_data), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    chk("reset_perr", 32'(parity_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(4);

    // Table-driven frames
    foreach (vecs[k]) begin
      n0 = new_cnt; f0 = ferr_cnt; p0 = perr_cnt; t0 = cyc;
      send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].bad_par);
      if (!vecs[k].stop_ok) begin
        tick(40);
        chk($sformatf("vec%0d_break_busy", k), 32'(busy), 32'd1);
        rx = 1'b1;
      end
      wait_idle($sformatf("vec%0d", k), 4 * C);
      tick(2);
      chk($sformatf("vec%0d_new_cnt", k), 32'(new_cnt - n0), 32'(vecs[k].exp_new));
      chk($sformatf("vec%0d_ferr_cnt", k), 32'(ferr_cnt - f0), 32'(vecs[k].exp_ferr));
      chk($sformatf("vec%0d_perr_cnt", k), 32'(perr_cnt - p0), 32'(vecs[k].exp_perr));
      chk($sformatf("vec%0d_rx_data", k), 32'(rx_data), 32'(vecs[k].exp_data));
      if (vecs[k].exp_new == 1 && got_data.size() > 0) begin
        chk($sformatf("vec%0d_pulse_data", k), 32'(got_data[$]), 32'(vecs[k].exp_data));
        chk($sformatf("vec%0d_latency_ok", k),
            32'((got_cyc[$] - t0 + 1 >= LAT) && (got_cyc[$] - t0 <= LAT + 1)), 32'd1);
      end
    end

    // Glitch shorter than half a bit
    n0 = new_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    rx = 1'b0;
    tick(4);
    chk("glitch_busy_high", 32'(busy), 32'd1);
    rx = 1'b1;
    tick(HB + 3 - 4);
    chk("glitch_busy_low", 32'(busy), 32'd0);
    tick(2 * C);
    chk("glitch_no_pulse", 32'((new_cnt - n0) + (ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);

    // Back-to-back frames with no idle gap
    n0 = new_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_idle("b2b", 4 * C);
    tick(2);
    chk("b2b_count", 32'(new_cnt - n0), 32'd2);
    if (new_cnt - n0 == 2) begin
      chk("b2b_first", 32'(got_data[got_data.size() - 2]), 32'h00);
      chk("b2b_second", 32'(got_data[got_data.size() - 1]), 32'hFF);
      chk("b2b_spacing", got_cyc[got_cyc.size() - 1] - got_cyc[got_cyc.size() - 2],
          32'(NBITS * C));
    end

    // Reset in the middle of bit 4 of 0x77
    n0 = new_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    rd = 8'h77;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = rd[i];
      tick(C);
    end
    rx = rd[4];
    tick(HB);
    rst = 1'b1;
    #1;
    chk("midrst_rx_data", 32'(rx_data), 32'h00);
    chk("midrst_new", 32'(new_rx_data), 32'd0);
    chk("midrst_ferr", 32'(frame_err), 32'd0);
    chk("midrst_perr", 32'(parity_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * C);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_idle("midrst", 4 * C);
    tick(2);
    chk("midrst_new_cnt", 32'(new_cnt - n0), 32'd1);
    chk("midrst_err_cnt", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
    chk("midrst_data", 32'(rx_data), 32'h5A);

    // Randomized frames against a queue model of accepted bytes
    base_idx = got_data.size();
    f0 = ferr_cnt; p0 = perr_cnt;
    exp_ferr_r = 0; exp_perr_r = 0;
    for (int i = 0; i < 40; i++) begin
      rd  = 8'($urandom_range(0, 255));
      rso = ($urandom_range(0, 7) != 0);
      rbp = PAR && ($urandom_range(0, 3) == 0);
      send_frame(rd, rso, rbp);
      if (!rso) begin
        exp_ferr_r++;
        tick($urandom_range(0, C));
        rx = 1'b1;
        tick(2);
      end else if (rbp) begin
        exp_perr_r++;
      end else begin
        exp_q.push_back(rd);
      end
      tick($urandom_range(0, 3));
    end
    wait_idle("rand", 4 * C);
    tick(2);
    chk("rand_count", 32'(got_data.size() - base_idx), 32'(exp_q.size()));
    chk("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr_r));
    chk("rand_perr", 32'(perr_cnt - p0), 32'(exp_perr_r));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_idx + i < got_data.size())
        chk($sformatf("rand_byte%0d", i), 32'(got_data[base_idx + i]), 32'(exp_q[i]));
    end

    chk("pulse_exclusive", 32'(excl_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
